lut2_mux_pipe: RTL and testbench

LUT2_MUX_PIPE -- requirements
Module: lut2_mux_pipe

---
 rtl/lut2_mux_pipe.sv | 115 +++++++++++
 tb/tb_lut2_mux_pipe.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut2_mux_pipe.sv
// lut2_mux_pipe: programmable 2-input bitwise function over a WIDTH-bit lane.
// Each bit is a 4:1 mux selecting a bit of a 4-bit truth table by {a_i, b_i}.
// Elementwise mode gives y = f(a, b). Reduce mode folds a burst of in_a words
// as acc = f(acc, in_a) and emits one result on the in_last beat.
// The output is a single-entry register with valid/ready handshakes.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   cfg_we, cfg_tt      truth-table load strobe and new table
//   in_valid/in_ready   input handshake; in_a, in_b, in_mode, in_last payload
//   out_valid/out_ready output handshake; out_y result word

// One bit of the function: a pure 4:1 mux tree over the truth table.
module lut2_mux_cell (
  input  logic [3:0] tt_i,
  input  logic       a_i,
  input  logic       b_i,
  output logic       y_o
);
  logic lo, hi;
  assign lo  = b_i ? tt_i[1] : tt_i[0];
  assign hi  = b_i ? tt_i[3] : tt_i[2];
  assign y_o = a_i ? hi : lo;
endmodule

module lut2_mux_pipe #(
  parameter int          WIDTH    = 8,
  parameter logic [3:0]  TT_RESET = 4'b0110
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_tt,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y
);
  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  state_t           state_q;
  logic [3:0]       tt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] y_q;
  logic             vld_q;

  logic [WIDTH-1:0] op_a, op_b, f_d;
  logic             accept;

  // One mux array serves both modes: inside a burst the operands are
  // (acc, in_a), otherwise (in_a, in_b). in_b never reaches the mux in ACC.
  assign op_a = (state_q == ACC) ? acc_q : in_a;
  assign op_b = (state_q == ACC) ? in_a  : in_b;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    lut2_mux_cell u_cell (
      .tt_i (tt_q),
      .a_i  (op_a[i]),
      .b_i  (op_b[i]),
      .y_o  (f_d[i])
    );
  end

  assign in_ready  = !vld_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = vld_q;
  assign out_y     = y_q;

  // tt_q is written after the mux has already used the old value this
  // cycle, so a cfg_we coinciding with a beat leaves that beat on the old table.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tt_q    <= TT_RESET;
      acc_q   <= '0;
      y_q     <= '0;
      vld_q   <= 1'b0;
    end else begin
      if (cfg_we) tt_q <= cfg_tt;
      if (vld_q && out_ready) vld_q <= 1'b0;
      if (accept) begin
        case (state_q)
          IDLE: begin
            if (!in_mode) begin
              y_q   <= f_d;
              vld_q <= 1'b1;
            end else if (in_last) begin
              // single-beat burst: nothing to fold, pass in_a through
              y_q   <= in_a;
              vld_q <= 1'b1;
            end else begin
              acc_q   <= in_a;
              state_q <= ACC;
            end
          end
          ACC: begin
            if (in_last) begin
              y_q     <= f_d;
              vld_q   <= 1'b1;
              state_q <= IDLE;
            end else begin
              acc_q <= f_d;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_lut2_mux_pipe.sv
module tb_lut2_mux_pipe;
  localparam int         W     = 8;
  localparam logic [3:0] TT_RS = 4'b0110;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_we;
  logic [3:0]   cfg_tt;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_mode;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_y;

  always #5 clk = ~clk;

  lut2_mux_pipe #(.WIDTH(W), .TT_RESET(TT_RS)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_tt(cfg_tt),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y)
  );

  int checks   = 0;
  int failures = 0;

  // reference model: expected result queue plus open-burst bookkeeping
  logic [W-1:0] q[$];
  logic         open_m;
  logic [W-1:0] acc_m;
  logic [3:0]   tt_m;
  logic         hold_chk;
  logic [W-1:0] hold_y;

  // y bit i is the truth-table entry addressed by {a_i, b_i}
  function automatic logic [W-1:0] fref(logic [3:0] tt, logic [W-1:0] a, logic [W-1:0] b);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = tt[{a[i], b[i]}];
    return r;
  endfunction

  // one clock: sample at negedge, score the handshakes, advance the model
  task automatic step();
    logic [W-1:0] e;
    @(negedge clk);
    checks++;
    if (out_valid !== (q.size() != 0)) begin
      failures++;
      $display("FAIL sb_valid: out_valid=%b expected=%b", out_valid, q.size() != 0);
    end
    checks++;
    if (in_ready !== ((q.size() == 0) || out_ready)) begin
      failures++;
      $display("FAIL sb_in_ready: in_ready=%b expected=%b", in_ready, (q.size() == 0) || out_ready);
    end
    if (hold_chk) begin
      checks++;
      if (out_valid !== 1'b1 || out_y !== hold_y) begin
        failures++;
        $display("FAIL stall_hold: out_valid=%b out_y=%h expected 1/%h", out_valid, out_y, hold_y);
      end
    end
    hold_chk = out_valid && !out_ready && rst_n;
    hold_y   = out_y;
    if (!rst_n) begin
      q.delete();
      open_m   = 1'b0;
      acc_m    = '0;
      tt_m     = TT_RS;
      hold_chk = 1'b0;
    end else begin
      if (out_valid && out_ready && q.size() != 0) begin
        e = q.pop_front();
        checks++;
        if (out_y !== e) begin
          failures++;
          $display("FAIL sb_data: out_y=%h expected=%h", out_y, e);
        end
      end
      if (in_valid && in_ready) begin
        if (!open_m && !in_mode) q.push_back(fref(tt_m, in_a, in_b));
        else if (!open_m) begin
          if (in_last) q.push_back(in_a);
          else begin acc_m = in_a; open_m = 1'b1; end
        end else begin
          acc_m = fref(tt_m, acc_m, in_a);
          if (in_last) begin q.push_back(acc_m); open_m = 1'b0; end
        end
      end
      if (cfg_we) tt_m = cfg_tt;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_we = 1'b1; cfg_tt = 4'b1111; in_valid = 1'b1;
    in_a = 8'hAA; in_b = 8'h55; in_mode = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q.delete(); open_m = 1'b0; acc_m = '0; tt_m = TT_RS; hold_chk = 1'b0; hold_y = '0;
    checks++;
    if (out_valid !== 1'b0 || out_y !== 8'h00) begin
      failures++;
      $display("FAIL reset_out: out_valid=%b out_y=%h expected 0/00", out_valid, out_y);
    end
    step();
    rst_n = 1'b1; cfg_we = 1'b0; in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: in_ready=%b expected 1", in_ready);
    end
  endtask

  task automatic test_elementwise();
    in_valid = 1'b1; in_mode = 1'b0; in_a = 8'hF0; in_b = 8'hCC; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_y !== 8'h3C) begin
      failures++;
      $display("FAIL elem_xor: out_valid=%b out_y=%h expected 1/3c", out_valid, out_y);
    end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_cfg();
    cfg_we = 1'b1; cfg_tt = 4'b1000;
    step();
    cfg_we = 1'b0; in_valid = 1'b1; in_mode = 1'b0; in_a = 8'hF0; in_b = 8'hCC; out_ready = 1'b0;
    step();
    checks++;
    if (out_y !== 8'hC0) begin
      failures++;
      $display("FAIL cfg_and: out_y=%h expected c0", out_y);
    end
    // new table with a beat and a consume in the same cycle
    cfg_we = 1'b1; cfg_tt = 4'b1110; in_a = 8'h0F; in_b = 8'h30; out_ready = 1'b1;
    step();
    cfg_we = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_y !== 8'h00) begin
      failures++;
      $display("FAIL cfg_same_cycle: out_valid=%b out_y=%h expected 1/00", out_valid, out_y);
    end
    step();
    checks++;
    if (out_y !== 8'h3F) begin
      failures++;
      $display("FAIL cfg_or: out_y=%h expected 3f", out_y);
    end
    in_valid = 1'b0; cfg_we = 1'b1; cfg_tt = TT_RS;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic test_reduce();
    logic [W-1:0] beats [4] = '{8'h01, 8'h02, 8'h04, 8'h80};
    out_ready = 1'b1; in_valid = 1'b1; in_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_a = beats[i]; in_b = W'($urandom); in_last = (i == 3);
      step();
      checks++;
      if (out_valid !== (i == 3)) begin
        failures++;
        $display("FAIL reduce_valid beat%0d: out_valid=%b expected %b", i, out_valid, i == 3);
      end
    end
    checks++;
    if (out_y !== 8'h87) begin
      failures++;
      $display("FAIL reduce_xor: out_y=%h expected 87", out_y);
    end
    in_valid = 1'b0; in_last = 1'b0;
    step();
  endtask

  task automatic test_stall();
    logic [W-1:0] a, b;
    in_valid = 1'b1; in_mode = 1'b0; in_a = 8'h11; in_b = 8'h22; out_ready = 1'b0;
    step();
    in_a = 8'h33; in_b = 8'h44;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_y !== 8'h33) begin
        failures++;
        $display("FAIL stall cyc%0d: in_ready=%b out_y=%h expected 0/33", i, in_ready, out_y);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_y !== 8'h77) begin
      failures++;
      $display("FAIL stall_release: out_valid=%b out_y=%h expected 1/77", out_valid, out_y);
    end
    for (int i = 0; i < 8; i++) begin
      a = W'($urandom); b = W'($urandom);
      in_a = a; in_b = b;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_y !== (a ^ b)) begin
        failures++;
        $display("FAIL back_to_back %0d: out_valid=%b out_y=%h expected 1/%h", i, out_valid, out_y, a ^ b);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_midburst();
    in_valid = 1'b1; in_mode = 1'b1; in_last = 1'b0; out_ready = 1'b1;
    in_a = 8'h12; step();
    in_a = 8'h34; step();
    in_valid = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midburst_reset: out_valid=%b expected 0", out_valid);
    end
    in_valid = 1'b1; in_mode = 1'b1; in_last = 1'b1; in_a = 8'h5A; in_b = 8'hFF;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_y !== 8'h5A) begin
      failures++;
      $display("FAIL after_reset_single: out_valid=%b out_y=%h expected 1/5a", out_valid, out_y);
    end
    step();
  endtask

  task automatic test_mode_toggle();
    out_ready = 1'b1;
    in_valid = 1'b1; in_mode = 1'b1; in_last = 1'b1; in_a = 8'h3C; in_b = 8'hFF;
    step();
    checks++;
    if (out_y !== 8'h3C) begin
      failures++;
      $display("FAIL single_beat: out_y=%h expected 3c", out_y);
    end
    in_mode = 1'b1; in_last = 1'b0; in_a = 8'h11; step();
    in_mode = 1'b0; in_a = 8'h22; in_b = 8'hFF; step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL toggle_no_out: out_valid=%b expected 0", out_valid);
    end
    in_last = 1'b1; in_a = 8'h44; in_b = 8'hA5; step();
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_y !== 8'h77) begin
      failures++;
      $display("FAIL toggle_reduce: out_valid=%b out_y=%h expected 1/77", out_valid, out_y);
    end
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_mode   = 1'($urandom_range(0, 1));
      in_last   = ($urandom_range(0, 2) == 0);
      cfg_we    = ($urandom_range(0, 15) == 0);
      cfg_tt    = 4'($urandom);
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      rst_n     = ($urandom_range(0, 99) != 0);
      step();
    end
    rst_n = 1'b1; in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    checks++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain: pending=%0d out_valid=%b expected 0/0", q.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_elementwise();
    test_cfg();
    test_reduce();
    test_stall();
    test_reset_midburst();
    test_mode_toggle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
